// File: rtl/serial_add_unit.sv
// Bit-serial WIDTH-bit adder: drives a single add1 full-adder cell, LSB first, one bit per clock.
// Optional signed-overflow output OVF is built when SERIAL_ADD_OVF_EN is defined.

module add1 (
    input  logic A,
    input  logic B,
    input  logic CI,
    output logic S,
    output logic CO
);
    assign S  = A ^ B ^ CI;
    assign CO = (A & B) | (CI & (A ^ B));
endmodule

module serial_add_unit #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] OPA,
    input  logic [WIDTH-1:0] OPB,
    input  logic             CIN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             OVF
`endif
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_sr, opb_sr;
    logic [WIDTH-2:0] sum_sr;  // bits already produced; the final bit goes straight into SUM
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             bit_s, bit_co;
    logic             accept, last_bit;

    add1 u_add1 (
        .A  (opa_sr[0]),
        .B  (opb_sr[0]),
        .CI (carry_q),
        .S  (bit_s),
        .CO (bit_co)
    );

    assign accept   = START && (state_q == IDLE || state_q == FIN);
    assign last_bit = (state_q == RUN) && (cnt_q == LAST);
    assign BUSY     = (state_q == RUN);
    assign DONE     = (state_q == FIN);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: state_d is defaulted before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (START) state_d = RUN;
            RUN:     if (cnt_q == LAST) state_d = FIN;
            FIN:     state_d = START ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            opa_sr  <= '0;
            opb_sr  <= '0;
            sum_sr  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            SUM     <= '0;
            COUT    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            OVF     <= 1'b0;
`endif
        end else if (accept) begin
            opa_sr  <= OPA;
            opb_sr  <= OPB;
            carry_q <= CIN;
            cnt_q   <= '0;
        end else if (state_q == RUN) begin
            sum_sr  <= (WIDTH-1)'({bit_s, sum_sr} >> 1);
            carry_q <= bit_co;
            opa_sr  <= opa_sr >> 1;
            opb_sr  <= opb_sr >> 1;
            if (!last_bit) cnt_q <= cnt_q + 1'b1;
            if (last_bit) begin
                SUM  <= {bit_s, sum_sr};
                COUT <= bit_co;
`ifdef SERIAL_ADD_OVF_EN
                OVF  <= carry_q ^ bit_co;
`endif
            end
        end
    end
endmodule

// File: tb/tb_serial_add_unit.sv
// Randomized self-checking bench for serial_add_unit (WIDTH=8) against an arithmetic reference model.
// Checks OVF as well when SERIAL_ADD_OVF_EN is defined.

module tb_serial_add_unit;
    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         START = 1'b0;
    logic [W-1:0] OPA = '0, OPB = '0;
    logic         CIN = 1'b0;
    logic         BUSY, DONE, COUT;
    logic [W-1:0] SUM;
`ifdef SERIAL_ADD_OVF_EN
    logic         OVF;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] prev_sum  = '0;
    logic         prev_cout = 1'b0;
    logic         prev_ovf  = 1'b0;

    serial_add_unit #(.WIDTH(W)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .OPA   (OPA),
        .OPB   (OPB),
        .CIN   (CIN),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .SUM   (SUM),
        .COUT  (COUT)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .OVF   (OVF)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_held(input string tag);
        check({tag, "_sum"}, SUM, prev_sum);
        check({tag, "_cout"}, COUT, prev_cout);
`ifdef SERIAL_ADD_OVF_EN
        check({tag, "_ovf"}, OVF, prev_ovf);
`endif
    endtask

    // Called at a negedge in IDLE or FIN; returns at the negedge inside the resulting FIN.
    // poke_at: RUN sample index where a stray START is raised; abort_at: index where RST hits.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                          input int poke_at, input int abort_at);
        logic [W:0] full;
        logic       exp_ovf;
        full    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        exp_ovf = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        START = 1'b1; OPA = a; OPB = b; CIN = ci;
        @(negedge CLK);
        START = 1'b0; OPA = W'($urandom); OPB = W'($urandom); CIN = 1'($urandom);
        for (int i = 0; i < W; i++) begin
            check("busy", BUSY, 1);
            check("done_low", DONE, 0);
            check_held("run_hold");
            if (i == abort_at) begin
                #1 RST = 1'b1;
                #1;
                check("rst_busy", BUSY, 0);
                check("rst_done", DONE, 0);
                prev_sum = '0; prev_cout = 1'b0; prev_ovf = 1'b0;
                check_held("rst");
                @(negedge CLK);
                RST = 1'b0;
                repeat (W + 2) begin
                    @(negedge CLK);
                    check("abort_no_done", DONE, 0);
                    check("abort_idle", BUSY, 0);
                end
                return;
            end
            if (i == poke_at) begin
                START = 1'b1; OPA = 8'hAA; OPB = 8'h55; CIN = 1'b1;
            end else begin
                START = 1'b0;
            end
            @(negedge CLK);
        end
        START = 1'b0;
        check("done", DONE, 1);
        check("busy_fin", BUSY, 0);
        check("sum", SUM, full[W-1:0]);
        check("cout", COUT, full[W]);
`ifdef SERIAL_ADD_OVF_EN
        check("ovf", OVF, exp_ovf);
`endif
        prev_sum = full[W-1:0]; prev_cout = full[W]; prev_ovf = exp_ovf;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLK);
            check("idle_busy", BUSY, 0);
            check("idle_done", DONE, 0);
            check_held("idle_hold");
        end
    endtask

    initial begin
        #2;
        check("reset_busy", BUSY, 0);
        check("reset_done", DONE, 0);
        check_held("reset");
        @(negedge CLK);
        RST = 1'b0;
        idle(1);

        run_op(8'h5A, 8'h3C, 1'b0, -1, -1); idle(1);
        run_op(8'hFF, 8'h01, 1'b0, -1, -1); idle(2);
        run_op(8'hFF, 8'h00, 1'b1, -1, -1); idle(1);
        run_op(8'h01, 8'h02, 1'b0, -1, -1);
        run_op(8'h10, 8'h20, 1'b0, -1, -1); idle(1);
        run_op(8'h12, 8'h34, 1'b0,  3, -1); idle(1);
        run_op(8'h33, 8'h44, 1'b0, -1,  4);
        run_op(8'h0F, 8'h01, 1'b0, -1, -1); idle(1);
        run_op(8'h7F, 8'h01, 1'b0, -1, -1); idle(1);
        run_op(8'h80, 8'h80, 1'b0, -1, -1); idle(1);
        run_op(8'hFF, 8'h01, 1'b0, -1, -1); idle(1);

        for (int k = 0; k < 40; k++) begin
            int poke;
            poke = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W - 1)) : -1;
            run_op(W'($urandom), W'($urandom), 1'($urandom), poke, -1);
            idle(int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
